// File: rtl/serial_pkg.sv
// Shared types and line constants for the serial transmit framer.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Per-bit clock divider: bit_tick marks the last clock of each serial bit.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);

  logic [CW-1:0] clk_cnt_q;
  logic [CW-1:0] clk_cnt_d;

  assign bit_tick = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  // Wrap on the last clock of a bit; with one clock per bit the count stays at zero.
  always_comb begin
    if (clr || bit_tick) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial frame transmitter: start, data, optional parity, stop.
// Define SERIAL_TX_FRAMER_PARITY_EN to insert an even-parity bit before stop.
module serial_tx_framer
  import serial_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = cnt_w(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_adv_s;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              serial_q, serial_d;
  logic              bit_tick_s, accept_s, last_bit_s, head_s, adv_head_s, idle_s;

  assign idle_s = (state_q == IDLE);

  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (idle_s),
    .bit_tick (bit_tick_s)
  );

  assign in_ready    = !rst && (idle_s || (state_q == STOP && bit_tick_s));
  assign accept_s    = in_valid && in_ready;
  assign last_bit_s  = (bit_cnt_q == BW'(DATA_W - 1));
  // The bit on the line is always the head of the shift register.
  assign shift_adv_s = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
  assign head_s      = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
  assign adv_head_s  = MSB_FIRST ? shift_adv_s[DATA_W-1] : shift_adv_s[0];
  assign busy        = !idle_s;
  assign frame_done  = (state_q == STOP) && bit_tick_s;
  assign serial_out  = serial_q;

`ifdef SERIAL_TX_FRAMER_PARITY_EN
  logic parity_q;

  // Even parity is taken over the whole word at capture time.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept_s) begin
      parity_q <= ^in_data;
    end else begin
      parity_q <= parity_q;
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = accept_s ? START : IDLE;
      START: state_d = bit_tick_s ? DATA : START;
      DATA: begin
        if (bit_tick_s && last_bit_s) begin
`ifdef SERIAL_TX_FRAMER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef SERIAL_TX_FRAMER_PARITY_EN
      PARITY: state_d = bit_tick_s ? STOP : PARITY;
`endif
      STOP: begin
        if (bit_tick_s) begin
          state_d = accept_s ? START : IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values, keyed on the state being entered.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    serial_d  = IDLE_LEVEL;
    if (accept_s) begin
      shift_d = in_data;
    end else if (state_q == DATA && bit_tick_s) begin
      shift_d = shift_adv_s;
    end else begin
      shift_d = shift_q;
    end
    if (state_q == DATA && bit_tick_s) begin
      bit_cnt_d = last_bit_s ? '0 : bit_cnt_q + BW'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    case (state_d)
      IDLE:  serial_d = IDLE_LEVEL;
      START: serial_d = START_BIT;
      DATA: begin
        if (state_q != DATA) begin
          serial_d = head_s;
        end else if (bit_tick_s) begin
          serial_d = adv_head_s;
        end else begin
          serial_d = serial_q;
        end
      end
`ifdef SERIAL_TX_FRAMER_PARITY_EN
      PARITY: serial_d = parity_q;
`endif
      STOP:    serial_d = STOP_BIT;
      default: serial_d = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer; honours SERIAL_TX_FRAMER_PARITY_EN.
module tb_serial_tx_framer;

`ifdef SERIAL_TX_FRAMER_PARITY_EN
  localparam int FLEN = 7;
  localparam logic [FLEN-1:0]   EXP1    = 7'b0101111;
  localparam logic [FLEN-1:0]   EXP2    = 7'b0100101;
  localparam logic [2*FLEN-1:0] EXP_B2B = 14'b0101111_0010011;
  localparam logic [FLEN-1:0]   EXP_B   = 7'b0100011;
`else
  localparam int FLEN = 6;
  localparam logic [FLEN-1:0]   EXP1    = 6'b010111;
  localparam logic [FLEN-1:0]   EXP2    = 6'b010011;
  localparam logic [2*FLEN-1:0] EXP_B2B = 12'b010111_001001;
  localparam logic [FLEN-1:0]   EXP_B   = 6'b010001;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid, a_ready, a_sout, a_busy, a_done;
  logic [3:0] a_data;
  logic       b_valid, b_ready, b_sout, b_busy, b_done;
  logic [3:0] b_data;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_tx_framer #(.DATA_W(4), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .serial_out(a_sout), .busy(a_busy), .frame_done(a_done)
  );

  serial_tx_framer #(.DATA_W(4), .CLKS_PER_BIT(3), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .serial_out(b_sout), .busy(b_busy), .frame_done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [3:0] w, input int j);
    if (j == 0) return 1'b0;
    else if (j >= 1 && j <= 4) return w[4-j];
`ifdef SERIAL_TX_FRAMER_PARITY_EN
    else if (j == 5) return ^w;
`endif
    else return 1'b1;
  endfunction

  task automatic send_frame_a(input logic [3:0] word, input logic [FLEN-1:0] exp, input string tag);
    logic [3:0] sr;
    sr = 4'b0000;
    a_valid = 1'b1;
    a_data  = word;
    chk({tag, "_ready_idle"}, a_ready, 1'b1);
    tick();
    a_valid = 1'b0;
    a_data  = ~word;
    for (int k = 0; k < FLEN; k++) begin
      chk($sformatf("%s_sout%0d", tag, k), a_sout, exp[FLEN-1-k]);
      chk($sformatf("%s_done%0d", tag, k), a_done, (k == FLEN-1));
      chk($sformatf("%s_ready%0d", tag, k), a_ready, (k == FLEN-1));
      chk($sformatf("%s_busy%0d", tag, k), a_busy, 1'b1);
      if (k >= 1 && k <= 4) sr = {sr[2:0], a_sout};
      tick();
    end
    chk({tag, "_shiftreg"}, sr, word);
    chk({tag, "_sout_end"}, a_sout, 1'b1);
    chk({tag, "_busy_end"}, a_busy, 1'b0);
    chk({tag, "_done_end"}, a_done, 1'b0);
  endtask

  initial begin
    int         rem;
    int         n_acc;
    logic [3:0] cur;
    logic [3:0] d;
    logic       v;
    logic       acc;

    a_valid = 1'b0; a_data = 4'h0;
    b_valid = 1'b0; b_data = 4'h0;
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_sout", a_sout, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_ready_b", b_ready, 1'b0);
    chk("rst_sout_b", b_sout, 1'b1);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", a_ready, 1'b1);

    // Single frames
    send_frame_a(4'b1011, EXP1, "t1");
    send_frame_a(4'b1001, EXP2, "t1b");

    // Back-to-back frames with valid held high
    a_valid = 1'b1;
    a_data  = 4'b1011;
    tick();
    a_data  = 4'b0100;
    for (int k = 0; k < 2*FLEN; k++) begin
      chk($sformatf("t2_sout%0d", k), a_sout, EXP_B2B[2*FLEN-1-k]);
      chk($sformatf("t2_done%0d", k), a_done, (k == FLEN-1) || (k == 2*FLEN-1));
      chk($sformatf("t2_ready%0d", k), a_ready, (k == FLEN-1) || (k == 2*FLEN-1));
      chk($sformatf("t2_busy%0d", k), a_busy, 1'b1);
      if (k >= FLEN) a_valid = 1'b0;
      tick();
    end
    chk("t2_idle_busy", a_busy, 1'b0);
    chk("t2_idle_sout", a_sout, 1'b1);

    // Stretched bits, LSB first
    chk("t3_busy_pre", b_busy, 1'b0);
    b_valid = 1'b1;
    b_data  = 4'b0001;
    tick();
    b_valid = 1'b0;
    b_data  = 4'b1110;
    for (int k = 0; k < 3*FLEN; k++) begin
      chk($sformatf("t3_sout%0d", k), b_sout, EXP_B[FLEN-1-(k/3)]);
      chk($sformatf("t3_busy%0d", k), b_busy, 1'b1);
      chk($sformatf("t3_done%0d", k), b_done, (k == 3*FLEN-1));
      chk($sformatf("t3_ready%0d", k), b_ready, (k == 3*FLEN-1));
      tick();
    end
    chk("t3_busy_end", b_busy, 1'b0);
    chk("t3_sout_end", b_sout, 1'b1);

    // Reset during the second data bit
    a_valid = 1'b1;
    a_data  = 4'b1011;
    tick();
    a_valid = 1'b0;
    tick();
    chk("t4_bit1", a_sout, 1'b1);
    tick();
    chk("t4_bit2", a_sout, 1'b0);
    rst = 1'b1;
    #1;
    chk("t4_ready_in_rst", a_ready, 1'b0);
    tick();
    chk("t4_sout_after", a_sout, 1'b1);
    chk("t4_busy_after", a_busy, 1'b0);
    chk("t4_done_after", a_done, 1'b0);
    chk("t4_ready_rst", a_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("t4_ready_post", a_ready, 1'b1);
    for (int k = 0; k < FLEN + 2; k++) begin
      chk($sformatf("t4_nodone%0d", k), a_done, 1'b0);
      chk($sformatf("t4_line%0d", k), a_sout, 1'b1);
      tick();
    end

    // Random valid and changing data against a frame-level model
    rem = 0;
    n_acc = 0;
    cur = 4'h0;
    for (int i = 0; i < 90; i++) begin
      v = (i < 75) ? 1'($urandom_range(0, 1)) : 1'b0;
      d = 4'($urandom_range(0, 15));
      a_valid = v;
      a_data  = d;
      #1;
      chk($sformatf("t6_ready%0d", i), a_ready, (rem <= 1));
      chk($sformatf("t6_sout%0d", i), a_sout, (rem == 0) ? 1'b1 : exp_bit(cur, FLEN - rem));
      chk($sformatf("t6_done%0d", i), a_done, (rem == 1));
      chk($sformatf("t6_busy%0d", i), a_busy, (rem != 0));
      acc = v && (rem <= 1);
      tick();
      if (acc) begin
        cur = d;
        rem = FLEN;
        n_acc++;
      end else if (rem > 0) begin
        rem--;
      end
    end
    chk("t6_accepts", (n_acc >= 3), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_framer.md
Name: serial_tx_framer

Overview:
Parallel-to-serial framer that sits directly upstream of the serial-in shift register stage and drives its serial input line. It accepts a DATA_W-bit word over a valid/ready handshake and emits one asynchronous-style frame on serial_out: start bit, data bits, optional parity bit, then stop bit. Each bit is held for CLKS_PER_BIT clocks. Back-to-back frames are supported with no idle gap.

Parameters:
DATA_W, 4, payload width in bits (>=1)
CLKS_PER_BIT, 1, clocks each serial bit is held (>=1)
MSB_FIRST, 1, 1 = in_data[DATA_W-1] sent first; 0 = in_data[0] sent first

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream word available
in_ready  out  1  framer can accept a word this cycle
in_data  in  DATA_W  word to transmit, sampled only on accept
serial_out  out  1  registered serial line, idle high
busy  out  1  high while a frame is in progress (state != IDLE)
frame_done  out  1  one-cycle pulse in the final clock of the stop bit

Behaviour:
- Reset: synchronous, active-high; clock clk. On rst, at the clock edge:
  - state goes to IDLE.
  - serial_out goes to 1.
  - bit and clock counters clear.
  - busy and frame_done are 0.
  - in_ready is 0 while rst is high.
- A reset in mid-frame aborts the frame immediately. The partial word is discarded and the line returns high on that edge.
- in_ready is combinational and equals !rst && (state==IDLE || (state==STOP && clk_cnt==CLKS_PER_BIT-1)).
- Accept occurs when in_valid && in_ready at a posedge. On that edge:
  - in_data is captured into an internal shift register.
  - state goes to START.
  - serial_out goes to 0.
- in_data changes after the accept have no effect on the frame.
- States:
  - IDLE: serial_out=1. Stays until accept.
  - START: serial_out=0 for CLKS_PER_BIT clocks, then DATA.
  - DATA: DATA_W bits, each held CLKS_PER_BIT clocks. The order is set by MSB_FIRST. After the last bit, go to PARITY if the feature is enabled, otherwise STOP.
  - PARITY: present only with the feature enabled; see Optional Feature.
  - STOP: serial_out=1 for CLKS_PER_BIT clocks. In its final clock frame_done=1. On exit, go to START if an accept occurs on that edge, else IDLE.
- serial_out is registered. The bit value changes on the same edge as the state or bit transition, and there is no combinational path from inputs to serial_out.
- Frame length without parity is (DATA_W+2)*CLKS_PER_BIT clocks. Back-to-back frames repeat with exactly that period.
- Counters:
  - clk_cnt is ceil(log2(CLKS_PER_BIT)) bits wide, minimum 1. It wraps to 0 at CLKS_PER_BIT-1.
  - bit_cnt is ceil(log2(DATA_W)) bits wide, minimum 1. It wraps to 0 on leaving DATA.
  - With CLKS_PER_BIT==1, clk_cnt is held at 0 and every bit is exactly one clock.
- If in_valid is held high in IDLE, accept happens on the first edge after rst deasserts.

Optional Feature:
Macro SERIAL_TX_FRAMER_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. serial_out carries even parity (XOR of all captured data bits) for CLKS_PER_BIT clocks. Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Decomposition:
- Package serial_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP; PARITY encoded even when the feature is off);
  - the constants START_BIT=1'b0, STOP_BIT=1'b1 and IDLE_LEVEL=1'b1.
- Sub-module serial_bit_timer: the CLKS_PER_BIT clock counter with clear input and a registered-free bit_tick output (high when clk_cnt==CLKS_PER_BIT-1).

Test Plan:
1. Basic frame: DATA_W=4, CLKS_PER_BIT=1, MSB_FIRST=1, no parity. Send 4'b1011. Required response:
   - serial_out = 0,1,0,1,1,1 on the six clocks after accept, then 1.
   - frame_done high in clock 6 only.
   - A downstream 4-bit serial-in shift register, after the four data clocks, holds 1011.
2. Back-to-back: in_valid held high with 4'b1011 then 4'b0100. Required response:
   - in_ready pulses in the final stop clock.
   - serial_out = 0,1,0,1,1,1,0,0,1,0,0,1 with no idle clock between frames.
   - two frame_done pulses, 6 clocks apart.
3. Stretched bits: CLKS_PER_BIT=3, send 4'b0001, MSB_FIRST=0. Required response:
   - serial_out = 000,111,000,000,000,111 (18 clocks).
   - busy high for exactly 18 clocks.
4. Reset mid-frame: assert rst for 1 clock during the 2nd data bit. Required response:
   - serial_out=1 and busy=0 after that edge.
   - in_ready=0 during rst and 1 the cycle after.
   - no frame_done pulse.
5. Parity (SERIAL_TX_FRAMER_PARITY_EN defined):
   - 4'b1011 gives 0,1,0,1,1,1,1.
   - 4'b1001 gives 0,1,0,0,1,0,1.
   - frame_done in clock 7.
6. Handshake hold: in_valid toggled randomly with data changing while busy. Required response:
   - only words present at accept edges are transmitted, in order.
   - in_data changes during a frame never alter serial_out.
